// File: rtl/cdc_handshake_tx.sv
// -----------------------------------------------------------------------------
// cdc_handshake_tx
// Source-domain side of a 4-phase req/ack clock-domain crossing. The block
// accepts one word from local logic, holds it on data_out and raises
// req_out. It then waits for the synchronized ack to rise, drops req_out,
// and waits for the ack to fall before it accepts the next word.
//
// Optional feature macro: CDC_TX_TIMEOUT_EN
//   When defined, the block aborts a request that has not been acknowledged
//   within TIMEOUT_CYC cycles and pulses err. When undefined, there is no
//   err port and the block waits in REQ indefinitely.
//
// Ports
//   clk_src   in   1       source-domain clock (rising edge)
//   rst       in   1       synchronous active-high reset
//   in_valid  in   1       local word offered
//   in_data   in   DATA_W  local word
//   in_ready  out  1       block can accept a word this cycle
//   data_out  out  DATA_W  registered word held toward the destination
//   req_out   out  1       registered request level toward the destination
//   ack_in    in   1       acknowledge level from destination (asynchronous)
//   done      out  1       one-cycle pulse when a transaction completes
//   err       out  1       one-cycle pulse on timeout abort (macro only)
// -----------------------------------------------------------------------------
module cdc_handshake_tx #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk_src,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              req_out,
  input  logic              ack_in,
`ifdef CDC_TX_TIMEOUT_EN
  output logic              err,
`endif
  output logic              done
);

  // Elaboration-time guard on the parameter ranges.
  if ((SYNC_STAGES < 2) || (SYNC_STAGES > 4) ||
      (TIMEOUT_CYC < 1) || (TIMEOUT_CYC > 65535)) begin : g_param_check
    $error("cdc_handshake_tx: parameter out of range");
  end

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_WAIT_LOW = 2'd2
  } state_t;

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [SYNC_STAGES-1:0] sync_r;
  logic                   ack_s;
  logic                   req_r;
  logic                   req_nxt_s;
  logic [DATA_W-1:0]      data_r;
  logic [DATA_W-1:0]      data_nxt_s;
  logic                   done_r;
  logic                   done_nxt_s;

`ifdef CDC_TX_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             err_r;
  logic             err_nxt_s;
  // Remembers that the current handshake was aborted, so its return-to-zero
  // phase does not report a completion.
  logic             abort_r;
  logic             abort_nxt_s;
`endif

  // ack_in synchronizer chain; only its last stage is used by the FSM.
  always_ff @(posedge clk_src) begin
    if (rst) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], ack_in};
    end
  end

  assign ack_s = sync_r[SYNC_STAGES-1];

  // A stale high ack blocks acceptance so no transaction starts against it.
  assign in_ready = (state_r == ST_IDLE) && !ack_s;

  // FSM next-state and next-output logic.
  always_comb begin
    state_nxt_s = state_r;
    req_nxt_s   = req_r;
    data_nxt_s  = data_r;
    done_nxt_s  = 1'b0;
`ifdef CDC_TX_TIMEOUT_EN
    cnt_nxt_s   = cnt_r;
    err_nxt_s   = 1'b0;
    abort_nxt_s = abort_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          state_nxt_s = ST_REQ;
          req_nxt_s   = 1'b1;
          data_nxt_s  = in_data;
`ifdef CDC_TX_TIMEOUT_EN
          cnt_nxt_s   = {CNT_W{1'b0}};
          abort_nxt_s = 1'b0;
`endif
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        // An ack arriving on the timeout cycle takes priority over the abort.
        if (ack_s) begin
          state_nxt_s = ST_WAIT_LOW;
          req_nxt_s   = 1'b0;
`ifdef CDC_TX_TIMEOUT_EN
        end else if (cnt_r == CNT_W'(TIMEOUT_CYC - 1)) begin
          // The count reaches TIMEOUT_CYC on this edge: abort.
          state_nxt_s = ST_WAIT_LOW;
          req_nxt_s   = 1'b0;
          err_nxt_s   = 1'b1;
          abort_nxt_s = 1'b1;
        end else begin
          cnt_nxt_s   = cnt_r + CNT_W'(1);
`else
        end else begin
          state_nxt_s = ST_REQ;
`endif
        end
      end
      ST_WAIT_LOW: begin
        if (!ack_s) begin
          state_nxt_s = ST_IDLE;
`ifdef CDC_TX_TIMEOUT_EN
          done_nxt_s  = !abort_r;
`else
          done_nxt_s  = 1'b1;
`endif
        end else begin
          state_nxt_s = ST_WAIT_LOW;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        req_nxt_s   = 1'b0;
      end
    endcase
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk_src) begin
    if (rst) begin
      state_r <= ST_IDLE;
      req_r   <= 1'b0;
      data_r  <= {DATA_W{1'b0}};
      done_r  <= 1'b0;
`ifdef CDC_TX_TIMEOUT_EN
      cnt_r   <= {CNT_W{1'b0}};
      err_r   <= 1'b0;
      abort_r <= 1'b0;
`endif
    end else begin
      state_r <= state_nxt_s;
      req_r   <= req_nxt_s;
      data_r  <= data_nxt_s;
      done_r  <= done_nxt_s;
`ifdef CDC_TX_TIMEOUT_EN
      cnt_r   <= cnt_nxt_s;
      err_r   <= err_nxt_s;
      abort_r <= abort_nxt_s;
`endif
    end
  end

  assign req_out  = req_r;
  assign data_out = data_r;
  assign done     = done_r;
`ifdef CDC_TX_TIMEOUT_EN
  assign err      = err_r;
`endif

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// -----------------------------------------------------------------------------
// tb_cdc_handshake_tx
// Self-checking bench for cdc_handshake_tx. A destination-side monitor pops
// the expected word from a scoreboard queue at every rising req_out edge.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_cdc_handshake_tx;

  localparam int S  = 2;
  localparam int DW = 8;

  typedef struct {
    logic [DW-1:0] din;
    logic [DW-1:0] exp_dout;
  } vec_t;

  logic          clk_src = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic [DW-1:0] data_out;
  logic          req_out;
  logic          ack_in;
  logic          done;
`ifdef CDC_TX_TIMEOUT_EN
  logic          err;
`endif

  logic          inst_mode;
  logic          ack_man;
  logic          req_prev = 1'b0;

  int            vec_cnt  = 0;
  int            mis_cnt  = 0;
  int            done_seen = 0;
  int            done_exp  = 0;
  int            err_seen  = 0;
  int            err_exp   = 0;
  logic [DW-1:0] exp_q[$];
  vec_t          vecs[4];

  // Destination model: either mirrors req_out instantly or follows ack_man.
  assign ack_in = inst_mode ? req_out : ack_man;

  cdc_handshake_tx #(
    .DATA_W     (DW),
    .SYNC_STAGES(S),
    .TIMEOUT_CYC(10)
  ) dut (
    .clk_src (clk_src),
    .rst     (rst),
    .in_valid(in_valid),
    .in_data (in_data),
    .in_ready(in_ready),
    .data_out(data_out),
    .req_out (req_out),
    .ack_in  (ack_in),
`ifdef CDC_TX_TIMEOUT_EN
    .err     (err),
`endif
    .done    (done)
  );

  always #5 clk_src = ~clk_src;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      mis_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk_src);
  endtask

  // Offer one word; it is expected at the destination only if accepted.
  task automatic offer(input logic [DW-1:0] d);
    in_data  = d;
    in_valid = 1'b1;
    if (in_ready) exp_q.push_back(d);
    step();
    in_valid = 1'b0;
  endtask

  // Destination monitor and pulse counters.
  always @(negedge clk_src) begin
    if (req_out === 1'b1 && req_prev === 1'b0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_req", 32'(data_out), 32'hFFFF_FFFF);
      end else begin
        check("dest_word", 32'(data_out), 32'(exp_q.pop_front()));
      end
    end
    if (done === 1'b1) done_seen++;
`ifdef CDC_TX_TIMEOUT_EN
    if (err === 1'b1) err_seen++;
`endif
    req_prev = req_out;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int k;
    vecs[0] = '{din: 8'h01, exp_dout: 8'h01};
    vecs[1] = '{din: 8'h02, exp_dout: 8'h02};
    vecs[2] = '{din: 8'h03, exp_dout: 8'h03};
    vecs[3] = '{din: 8'h04, exp_dout: 8'h04};

    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; ack_man = 1'b0; inst_mode = 1'b0;

    // Reset state
    step(); step();
    rst = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_req",      32'(req_out),  32'd0);
    check("rst_data",     32'(data_out), 32'd0);
    check("rst_done",     32'(done),     32'd0);

    // Basic transfer with busy-ignore during REQ
    offer(8'hA5);
    check("basic_req",   32'(req_out),  32'd1);
    check("basic_data",  32'(data_out), 32'hA5);
    check("basic_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1; in_data = 8'h3C;
    for (int i = 0; i < 3; i++) begin
      step();
      check("busy_data", 32'(data_out), 32'hA5);
      check("busy_req",  32'(req_out),  32'd1);
    end
    in_valid = 1'b0;
    ack_man = 1'b1;
    for (int i = 0; i < S; i++) begin
      step();
      check("ack_sync_req_high", 32'(req_out), 32'd1);
    end
    step();
    check("ack_req_low", 32'(req_out), 32'd0);
    ack_man = 1'b0;
    for (int i = 0; i < S; i++) begin
      step();
      check("rtz_done_low", 32'(done),     32'd0);
      check("rtz_not_ready", 32'(in_ready), 32'd0);
    end
    step();
    check("rtz_done",  32'(done),     32'd1);
    check("rtz_ready", 32'(in_ready), 32'd1);
    check("rtz_hold",  32'(data_out), 32'hA5);
    done_exp++;
    step();
    check("done_one_cycle", 32'(done), 32'd0);

    // Stale ack held across reset
    rst = 1'b1; ack_man = 1'b1;
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < S; i++) step();
    check("stale_not_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1; in_data = 8'h77;
    step(); step();
    check("stale_no_req",  32'(req_out),  32'd0);
    check("stale_data",    32'(data_out), 32'd0);
    in_valid = 1'b0;
    ack_man = 1'b0;
    for (int i = 0; i < S - 1; i++) begin
      step();
      check("stale_wait", 32'(in_ready), 32'd0);
    end
    step();
    check("stale_release", 32'(in_ready), 32'd1);

    // Reset while a request is outstanding
    offer(8'h5A);
    check("midreq_req", 32'(req_out), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midreq_req_low", 32'(req_out),  32'd0);
    check("midreq_data",    32'(data_out), 32'd0);
    check("midreq_ready",   32'(in_ready), 32'd1);

    // Back-to-back with an instantly responding destination
    inst_mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      offer(vecs[i].din);
      check("b2b_data", 32'(data_out), 32'(vecs[i].exp_dout));
      check("b2b_req",  32'(req_out),  32'd1);
      for (k = 1; k <= 40; k++) begin
        step();
        if (in_ready) break;
      end
      check("b2b_spacing", 32'(k),    32'(2 * S + 2));
      check("b2b_done",    32'(done), 32'd1);
      done_exp++;
    end
    inst_mode = 1'b0;
    step();

`ifdef CDC_TX_TIMEOUT_EN
    // Timeout abort with no acknowledge
    offer(8'h99);
    check("to_req", 32'(req_out), 32'd1);
    for (int i = 1; i < 10; i++) begin
      step();
      check("to_no_err", 32'(err),     32'd0);
      check("to_req_hi", 32'(req_out), 32'd1);
    end
    step();
    check("to_err",    32'(err),     32'd1);
    check("to_req_lo", 32'(req_out), 32'd0);
    err_exp++;
    step();
    check("to_err_one",  32'(err),      32'd0);
    check("to_req_stay", 32'(req_out),  32'd0);
    check("to_ready",    32'(in_ready), 32'd1);
    check("to_no_done",  32'(done),     32'd0);
    step(); step();
`endif

    check("done_total", 32'(done_seen), 32'(done_exp));
    check("err_total",  32'(err_seen),  32'(err_exp));
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
    $finish;
  end

endmodule

// File: doc/cdc_handshake_tx.md
# cdc_handshake_tx

Source-domain transmitter for a 4-phase req/ack clock-domain-crossing handshake. It accepts one data word per transaction from local logic, holds it stable on a bus, and raises `req_out` toward the destination domain. It synchronizes the returning `ack_in` through its own flop chain and completes the return-to-zero phase before it accepts the next word. It is the sending counterpart of the destination-side 2-FF synchronizer and receiver used on the same crossing.

## Interface
Parameters:
- `DATA_W`, 8: width of the transferred word.
- `SYNC_STAGES`, 2: flops in the `ack_in` synchronizer chain; legal range 2–4.
- `TIMEOUT_CYC`, 255: cycles allowed in REQ before abort. Used only when `CDC_TX_TIMEOUT_EN` is defined. Legal range 1–65535.

Ports:
- `clk_src`  in  1  source-domain clock; all logic on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `in_valid`  in  1  local word offered.
- `in_data`  in  DATA_W  local word.
- `in_ready`  out  1  block can accept a word this cycle.
- `data_out`  out  DATA_W  held word toward the destination domain; registered.
- `req_out`  out  1  request level toward the destination domain; registered, glitch-free.
- `ack_in`  in  1  acknowledge level from the destination domain; asynchronous to `clk_src`.
- `done`  out  1  one-cycle pulse when a transaction fully completes.
- `err`  out  1  one-cycle pulse on timeout abort. Present only with `CDC_TX_TIMEOUT_EN`.

## Operation
- `ack_in` passes through `SYNC_STAGES` flops. The last flop is `ack_s`. The FSM uses only `ack_s`.
- FSM states:
  - IDLE:
    - `in_ready = (state==IDLE) && !ack_s`.
    - When `in_valid && in_ready`: capture `in_data` into `data_out`, set `req_out=1`, go to REQ.
  - REQ:
    - `data_out` is frozen.
    - When `ack_s==1`: clear `req_out`, go to WAIT_LOW.
  - WAIT_LOW:
    - `req_out=0`.
    - When `ack_s==0`: go to IDLE and pulse `done` in the same register update.
- In IDLE, a stale `ack_s==1` blocks acceptance (`in_ready=0`) until it falls. No transaction starts against a high ack.
- `in_valid` in REQ or WAIT_LOW is ignored. `in_data` is not sampled and no state changes.
- `data_out` changes only on acceptance. It holds its last value through WAIT_LOW and IDLE.
- `req_out` changes only on the IDLE→REQ transition and on leaving REQ. It never toggles in any other state.
- Reset takes effect on the next `clk_src` edge:
  - state = IDLE
  - `req_out=0`, `data_out=0`, `done=0`, `err=0`
  - sync chain = 0
  - `in_ready` reads 1 on the cycle after reset
- Reset mid-transaction drops `req_out` immediately. The destination must tolerate an abandoned request.

## Timing
- Acceptance at edge N makes `req_out=1` and `data_out` valid after edge N.
- `ack_in` rising is seen in `ack_s` `SYNC_STAGES` edges later. `req_out` falls 1 edge after that.
- `ack_in` falling is seen in `ack_s` `SYNC_STAGES` edges later. `done` pulses and `in_ready` returns 1 on the following cycle.
- Minimum transaction, with the destination responding instantly: 2·SYNC_STAGES + 2 cycles from acceptance to the next `in_ready`.
- Throughput is one word per complete 4-phase cycle. There is no buffering.
- `ack_in` rise and `rst` on the same edge: reset wins.

## Configuration
- Macro `CDC_TX_TIMEOUT_EN`.
- Defined:
  - A counter, `$clog2(TIMEOUT_CYC+1)` bits wide, clears on entry to REQ and increments each cycle in REQ.
  - When it reaches `TIMEOUT_CYC` with `ack_s==0`: clear `req_out`, pulse `err` for one cycle, go to WAIT_LOW. No `done` follows an aborted transaction.
  - If `ack_s==1` arrives on the same cycle the counter reaches `TIMEOUT_CYC`, the ack wins and there is no `err`.
- Not defined: no counter, no `err` port, and REQ waits indefinitely.

## Test plan
- Basic transfer: reset, then `in_data=0xA5` with `in_valid=1` → `req_out=1` and `data_out=0xA5` next cycle. Drive `ack_in=1` 3 cycles later → `req_out=0` `SYNC_STAGES+1` cycles after. Drop `ack_in` → `done` pulses once and `in_ready=1`.
- Busy-ignore: during REQ present `in_data=0x3C` with `in_valid=1` → `data_out` stays 0xA5 and no second request is issued.
- Back-to-back: 4 words 0x01–0x04 with an instant-response destination model → 4 `done` pulses, words received in order, spacing exactly 2·SYNC_STAGES+2 cycles.
- Stale ack: hold `ack_in=1` after reset → `in_ready=0`. Release it → `in_ready=1` after `SYNC_STAGES` cycles.
- Reset mid-REQ: assert `rst` for 1 cycle while `req_out=1` → `req_out=0`, `data_out=0x00`, `in_ready=1` afterward.
- Timeout (macro on, `TIMEOUT_CYC=10`): never ack → `err` pulses exactly once, 10 cycles after entering REQ, with `req_out=0` from that point on. Then `in_ready=1` and no `done` pulse.
